// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared constants, FSM state encoding and helpers for the iterative divider.
//   DIV_ITER      number of restoring steps per divide (one quotient bit per step)
//   DIV_STATE_WD  width of the divider FSM state
//   div_state_t   IDLE / CALC / DONE
//   abs_val       two's-complement magnitude when the sign flag is set
package div_ctrl_pkg;
   localparam int DIV_ITER = 32;
   localparam int DIV_STATE_WD = 2;
   localparam logic [5:0] DIV_LAST = 6'(DIV_ITER - 1);
   typedef enum logic [DIV_STATE_WD-1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;
   function automatic logic [31:0] abs_val(input logic [31:0] v, input logic s);
      return s ? -v : v;
   endfunction
endpackage

// File: rtl/div_ctrl_step.sv
// div_ctrl_step: one combinational radix-2 restoring division step.
//   rem    current partial remainder (always < dvs)
//   dvd    dividend bits still to shift in (MSB next); quotient bits fill from the LSB
//   dvs    divisor magnitude
//   rem_n  partial remainder after this step
//   dvd_n  dvd shifted left with the new quotient bit appended
module div_ctrl_step (
   input  logic [31:0] rem,
   input  logic [31:0] dvd,
   input  logic [31:0] dvs,
   output logic [31:0] rem_n,
   output logic [31:0] dvd_n
);
   logic [32:0] sh;
   logic [31:0] diff;
   logic ge;
   // sh is the 33-bit shifted partial remainder; when sh >= dvs the true
   // difference is below dvs, so the low 32 bits of the subtract are exact.
   assign sh = {rem, dvd[31]};
   assign ge = sh >= {1'b0, dvs};
   assign diff = sh[31:0] - dvs;
   assign rem_n = ge ? diff : sh[31:0];
   assign dvd_n = {dvd[30:0], ge};
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: 32-cycle iterative signed/unsigned divider controller for the EXE stage.
//   clk, reset    clock; synchronous active-high reset
//   div_en        divide op present in EXE (level, held until it leaves EXE)
//   div_signed    1 = signed divide, 0 = unsigned
//   div_x, div_y  dividend / divisor, sampled only when a divide starts
//   div_accept    EXE op handed to MEM this cycle
//   flush         exception or ertn flush; abandons any divide
//   div_complete  div_q / div_r valid (high exactly while in DONE)
//   div_busy      FSM not IDLE
//   div_q, div_r  registered quotient / remainder
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        div_en,
   input  logic        div_signed,
   input  logic [31:0] div_x,
   input  logic [31:0] div_y,
   input  logic        div_accept,
   input  logic        flush,
   output logic        div_complete,
   output logic        div_busy,
   output logic [31:0] div_q,
   output logic [31:0] div_r
);
   div_state_t state;
   logic [5:0] cnt;
   logic [31:0] rem, dvd, dvs, rem_n, dvd_n;
   logic sx, sy, neg_q;
   div_ctrl_step u_step (.rem(rem), .dvd(dvd), .dvs(dvs), .rem_n(rem_n), .dvd_n(dvd_n));
   // Divide by zero yields all-ones regardless of signs, so no quotient negation then.
   assign neg_q = (sx ^ sy) && (dvs != '0);
   assign div_busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         rem <= '0;
         dvd <= '0;
         dvs <= '0;
         sx <= 1'b0;
         sy <= 1'b0;
         div_complete <= 1'b0;
         div_q <= '0;
         div_r <= '0;
      end else if (flush) begin
         state <= IDLE;
         div_complete <= 1'b0;
      end else begin
         case (state)
            IDLE: if (div_en) begin
               state <= CALC;
               cnt <= '0;
               rem <= '0;
               sx <= div_signed & div_x[31];
               sy <= div_signed & div_y[31];
               dvd <= abs_val(div_x, div_signed & div_x[31]);
               dvs <= abs_val(div_y, div_signed & div_y[31]);
            end
            CALC: if (!div_en) begin
               state <= IDLE;
            end else begin
               rem <= rem_n;
               dvd <= dvd_n;
               cnt <= cnt + 6'd1;
               if (cnt == DIV_LAST) begin
                  state <= DONE;
                  div_complete <= 1'b1;
                  div_q <= neg_q ? -dvd_n : dvd_n;
                  div_r <= sx ? -rem_n : rem_n;
               end
            end
            DONE: if (div_accept || !div_en) begin
               state <= IDLE;
               div_complete <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
